fp_alu_issuer: RTL and testbench

- Sequencing initiator for the combinational fixed-point ALU.
- Accepts 3-operand instructions over a valid/ready handshake and reads operands from an internal 16-entry register file.
- Drives the ALU operand and select ports, then captures the ALU result and compare flags back into the register file and flag register.
- Routes opcode 3'b010 (inverse sqrt) to the separate multi-cycle isqrt unit through a request/done handshake.

---
 rtl/fp_alu_issuer.sv | 211 +++++++++++++++++++++
 tb/tb_fp_alu_issuer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_issuer.sv
// Instruction issuer for the fixed-point ALU and the multi-cycle isqrt unit.
// Optional isqrt wait timeout is enabled by defining ALU_ISSUER_TIMEOUT_EN.
`ifndef NUM_ALL_DIGITS
`define NUM_ALL_DIGITS 16
`endif

module fp_alu_issuer #(
  parameter int unsigned WIDTH          = `NUM_ALL_DIGITS,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             instr_valid_in,
  output logic             instr_ready_out,
  input  logic [2:0]       instr_op_in,
  input  logic [3:0]       instr_rd_in,
  input  logic [3:0]       instr_rsa_in,
  input  logic [3:0]       instr_rsb_in,
  input  logic             wr_en_in,
  input  logic [3:0]       wr_addr_in,
  input  logic [WIDTH-1:0] wr_data_in,
  input  logic [3:0]       rd_addr_in,
  output logic [WIDTH-1:0] rd_data_out,
  output logic [WIDTH-1:0] alu_d1_out,
  output logic [WIDTH-1:0] alu_d0_out,
  output logic [2:0]       alu_sel_out,
  input  logic [WIDTH-1:0] alu_res_in,
  input  logic             alu_gt_in,
  input  logic             alu_eq_in,
  input  logic             alu_lt_in,
  output logic             isqrt_valid_out,
  output logic [WIDTH-1:0] isqrt_x_out,
  input  logic             isqrt_ready_in,
  input  logic             isqrt_done_in,
  input  logic [WIDTH-1:0] isqrt_res_in,
  output logic             flag_gt_out,
  output logic             flag_eq_out,
  output logic             flag_lt_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_out
);

  typedef enum logic [2:0] {IDLE, EXEC, ISQ_REQ, ISQ_WAIT, WB} state_t;

  localparam logic [2:0] OP_ISQRT = 3'b010;
  localparam logic [2:0] OP_NOP   = 3'b111;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       rd_q, rd_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             cgt_q, cgt_d, ceq_q, ceq_d, clt_q, clt_d;
  logic             flag_gt_q, flag_gt_d, flag_eq_q, flag_eq_d, flag_lt_q, flag_lt_d;
  logic [WIDTH-1:0] regs_q [16];
  logic [WIDTH-1:0] regs_d [16];
  logic             accept;

`ifdef ALU_ISSUER_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  assign accept = instr_valid_in && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cgt_d     = cgt_q;
    ceq_d     = ceq_q;
    clt_d     = clt_q;
    flag_gt_d = flag_gt_q;
    flag_eq_d = flag_eq_q;
    flag_lt_d = flag_lt_q;
    regs_d    = regs_q;

    // Host write first so a same-address writeback below overrides it.
    if (wr_en_in) regs_d[wr_addr_in] = wr_data_in;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = instr_op_in;
          rd_d    = instr_rd_in;
          a_d     = regs_q[instr_rsa_in];
          b_d     = regs_q[instr_rsb_in];
          state_d = (instr_op_in == OP_ISQRT) ? ISQ_REQ : EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_res_in;
        cgt_d   = alu_gt_in;
        ceq_d   = alu_eq_in;
        clt_d   = alu_lt_in;
        state_d = WB;
      end
      ISQ_REQ: begin
        if (isqrt_ready_in) state_d = ISQ_WAIT;
      end
      ISQ_WAIT: begin
        if (isqrt_done_in) begin
          res_d   = isqrt_res_in;
          state_d = WB;
        end
      end
      WB: begin
        if (op_q != OP_NOP) regs_d[rd_q] = res_q;
        if (op_q != OP_NOP && op_q != OP_ISQRT) begin
          flag_gt_d = cgt_q;
          flag_eq_d = ceq_q;
          flag_lt_d = clt_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    regs_d[0] = '0;
  end

`ifdef ALU_ISSUER_TIMEOUT_EN
  // A done strobe arriving on the expiry cycle still delivers the real result.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == ISQ_REQ || state_q == ISQ_WAIT) cnt_d = cnt_q + 1'b1;
    if (accept) cnt_d = '0;
    if ((state_q == ISQ_REQ || (state_q == ISQ_WAIT && !isqrt_done_in)) &&
        cnt_q == CW'(TIMEOUT_CYCLES)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign err_out        = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      cgt_q     <= 1'b0;
      ceq_q     <= 1'b0;
      clt_q     <= 1'b0;
      flag_gt_q <= 1'b0;
      flag_eq_q <= 1'b0;
      flag_lt_q <= 1'b0;
      regs_q    <= '{default: '0};
    end else begin
`ifdef ALU_ISSUER_TIMEOUT_EN
      if (err_d && !err_q) begin
        state_q <= WB;
        res_q   <= {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        state_q <= state_d;
        res_q   <= res_d;
      end
`else
      state_q   <= state_d;
      res_q     <= res_d;
`endif
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cgt_q     <= cgt_d;
      ceq_q     <= ceq_d;
      clt_q     <= clt_d;
      flag_gt_q <= flag_gt_d;
      flag_eq_q <= flag_eq_d;
      flag_lt_q <= flag_lt_d;
      regs_q    <= regs_d;
    end
  end

  assign instr_ready_out = rst_n_in && (state_q == IDLE);
  assign busy_out        = (state_q != IDLE);
  assign done_out        = (state_q == WB);
  assign rd_data_out     = regs_q[rd_addr_in];
  assign alu_d1_out      = (state_q == EXEC) ? a_q : '0;
  assign alu_d0_out      = (state_q == EXEC) ? b_q : '0;
  assign alu_sel_out     = !rst_n_in ? 3'b000 : ((state_q == EXEC) ? op_q : OP_NOP);
  assign isqrt_valid_out = (state_q == ISQ_REQ);
  assign isqrt_x_out     = (state_q == ISQ_REQ) ? a_q : '0;
  assign flag_gt_out     = flag_gt_q;
  assign flag_eq_out     = flag_eq_q;
  assign flag_lt_out     = flag_lt_q;

endmodule

// File: tb/tb_fp_alu_issuer.sv
// Directed self-checking bench for fp_alu_issuer; the bench plays both the ALU and isqrt unit.
module tb_fp_alu_issuer;

  localparam int unsigned W = 16;
`ifdef ALU_ISSUER_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic         clk_in, rst_n_in;
  logic         instr_valid_in, instr_ready_out;
  logic [2:0]   instr_op_in;
  logic [3:0]   instr_rd_in, instr_rsa_in, instr_rsb_in;
  logic         wr_en_in;
  logic [3:0]   wr_addr_in, rd_addr_in;
  logic [W-1:0] wr_data_in, rd_data_out;
  logic [W-1:0] alu_d1_out, alu_d0_out, alu_res_in;
  logic [2:0]   alu_sel_out;
  logic         alu_gt_in, alu_eq_in, alu_lt_in;
  logic         isqrt_valid_out, isqrt_ready_in, isqrt_done_in;
  logic [W-1:0] isqrt_x_out, isqrt_res_in;
  logic         flag_gt_out, flag_eq_out, flag_lt_out;
  logic         busy_out, done_out, err_out;

  int n_cmp = 0;
  int n_bad = 0;

  fp_alu_issuer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .instr_op_in(instr_op_in), .instr_rd_in(instr_rd_in),
    .instr_rsa_in(instr_rsa_in), .instr_rsb_in(instr_rsb_in),
    .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .rd_addr_in(rd_addr_in), .rd_data_out(rd_data_out),
    .alu_d1_out(alu_d1_out), .alu_d0_out(alu_d0_out), .alu_sel_out(alu_sel_out),
    .alu_res_in(alu_res_in), .alu_gt_in(alu_gt_in), .alu_eq_in(alu_eq_in), .alu_lt_in(alu_lt_in),
    .isqrt_valid_out(isqrt_valid_out), .isqrt_x_out(isqrt_x_out),
    .isqrt_ready_in(isqrt_ready_in), .isqrt_done_in(isqrt_done_in), .isqrt_res_in(isqrt_res_in),
    .flag_gt_out(flag_gt_out), .flag_eq_out(flag_eq_out), .flag_lt_out(flag_lt_out),
    .busy_out(busy_out), .done_out(done_out), .err_out(err_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // ALU inputs carry junk outside EXEC so a mistimed capture shows up.
  task automatic alu_junk();
    alu_res_in = 16'hDEAD;
    alu_gt_in  = 1'b1;
    alu_eq_in  = 1'b1;
    alu_lt_in  = 1'b1;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [W-1:0] d);
    wr_en_in   = 1'b1;
    wr_addr_in = a;
    wr_data_in = d;
    tick();
    wr_en_in   = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [W-1:0] v);
    rd_addr_in = a;
    #1;
    v = rd_data_out;
  endtask

  // Issues one ALU-path instruction; optional host write lands in the WB cycle.
  task automatic do_alu(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rsa,
                        input logic [3:0] rsb, input logic [W-1:0] res,
                        input logic g, input logic e, input logic l,
                        input logic hw, input logic [3:0] ha, input logic [W-1:0] hd,
                        output logic [W-1:0] d1, output logic [W-1:0] d0,
                        output logic [2:0] sel, output logic rdy, output logic dn_early,
                        output logic dn);
    rdy            = instr_ready_out;
    instr_valid_in = 1'b1;
    instr_op_in    = op;
    instr_rd_in    = rd;
    instr_rsa_in   = rsa;
    instr_rsb_in   = rsb;
    tick();
    instr_valid_in = 1'b0;
    d1             = alu_d1_out;
    d0             = alu_d0_out;
    sel            = alu_sel_out;
    dn_early       = done_out;
    alu_res_in     = res;
    alu_gt_in      = g;
    alu_eq_in      = e;
    alu_lt_in      = l;
    tick();
    alu_junk();
    dn         = done_out;
    wr_en_in   = hw;
    wr_addr_in = ha;
    wr_data_in = hd;
    tick();
    wr_en_in   = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (instr_ready_out !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", instr_ready_out); end
    n_cmp++; if ({flag_gt_out, flag_eq_out, flag_lt_out} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {flag_gt_out, flag_eq_out, flag_lt_out}); end
    n_cmp++; if ({busy_out, done_out, isqrt_valid_out, err_out} !== 4'b0000) begin n_bad++; $display("FAIL reset_ctl: got %b want 0000", {busy_out, done_out, isqrt_valid_out, err_out}); end
    n_cmp++; if (alu_sel_out !== 3'b000) begin n_bad++; $display("FAIL reset_sel: got %b want 000", alu_sel_out); end
    @(negedge clk_in);
    rst_n_in = 1'b1;
    tick();
    n_cmp++; if (instr_ready_out !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", instr_ready_out); end
    n_cmp++; if (alu_sel_out !== 3'b111) begin n_bad++; $display("FAIL idle_sel: got %b want 111", alu_sel_out); end
  endtask

  task automatic test_readback();
    logic [W-1:0] v;
    host_write(4'd1, 16'd5);
    host_write(4'd2, 16'd3);
    host_write(4'd0, 16'h00AA);
    read_reg(4'd1, v);
    n_cmp++; if (v !== 16'd5) begin n_bad++; $display("FAIL read_r1: got %h want 0005", v); end
    read_reg(4'd2, v);
    n_cmp++; if (v !== 16'd3) begin n_bad++; $display("FAIL read_r2: got %h want 0003", v); end
    read_reg(4'd0, v);
    n_cmp++; if (v !== 16'd0) begin n_bad++; $display("FAIL read_r0: got %h want 0000", v); end
  endtask

  task automatic test_sub();
    logic [W-1:0] d1, d0, v;
    logic [2:0]   sel;
    logic         rdy, dne, dn;
    do_alu(3'b100, 4'd3, 4'd2, 4'd1, 16'hFFFE, 1'b0, 1'b0, 1'b1,
           1'b0, 4'd0, 16'd0, d1, d0, sel, rdy, dne, dn);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL sub_ready: got %b want 1", rdy); end
    n_cmp++; if (d1 !== 16'd3) begin n_bad++; $display("FAIL sub_d1: got %h want 0003", d1); end
    n_cmp++; if (d0 !== 16'd5) begin n_bad++; $display("FAIL sub_d0: got %h want 0005", d0); end
    n_cmp++; if (sel !== 3'b100) begin n_bad++; $display("FAIL sub_sel: got %b want 100", sel); end
    n_cmp++; if ({dne, dn} !== 2'b01) begin n_bad++; $display("FAIL sub_done_timing: got %b want 01", {dne, dn}); end
    read_reg(4'd3, v);
    n_cmp++; if (v !== 16'hFFFE) begin n_bad++; $display("FAIL sub_r3: got %h want fffe", v); end
    n_cmp++; if ({flag_gt_out, flag_eq_out, flag_lt_out} !== 3'b001) begin n_bad++; $display("FAIL sub_flags: got %b want 001", {flag_gt_out, flag_eq_out, flag_lt_out}); end
    n_cmp++; if ({instr_ready_out, busy_out} !== 2'b10) begin n_bad++; $display("FAIL sub_idle: got %b want 10", {instr_ready_out, busy_out}); end
  endtask

  task automatic test_wb_conflict();
    logic [W-1:0] d1, d0, v;
    logic [2:0]   sel;
    logic         rdy, dne, dn;
    do_alu(3'b000, 4'd4, 4'd1, 4'd2, 16'd8, 1'b1, 1'b0, 1'b0,
           1'b1, 4'd4, 16'd99, d1, d0, sel, rdy, dne, dn);
    read_reg(4'd4, v);
    n_cmp++; if (v !== 16'd8) begin n_bad++; $display("FAIL conflict_same_r4: got %h want 0008", v); end
    n_cmp++; if ({flag_gt_out, flag_eq_out, flag_lt_out} !== 3'b100) begin n_bad++; $display("FAIL add_flags: got %b want 100", {flag_gt_out, flag_eq_out, flag_lt_out}); end
    host_write(4'd4, 16'd0);
    do_alu(3'b000, 4'd4, 4'd1, 4'd2, 16'd8, 1'b1, 1'b0, 1'b0,
           1'b1, 4'd5, 16'd99, d1, d0, sel, rdy, dne, dn);
    read_reg(4'd4, v);
    n_cmp++; if (v !== 16'd8) begin n_bad++; $display("FAIL conflict_diff_r4: got %h want 0008", v); end
    read_reg(4'd5, v);
    n_cmp++; if (v !== 16'd99) begin n_bad++; $display("FAIL conflict_diff_r5: got %h want 0063", v); end
  endtask

  task automatic test_nop_r0();
    logic [W-1:0] d1, d0, v;
    logic [2:0]   sel;
    logic         rdy, dne, dn;
    do_alu(3'b111, 4'd3, 4'd1, 4'd2, 16'h7777, 1'b0, 1'b1, 1'b0,
           1'b0, 4'd0, 16'd0, d1, d0, sel, rdy, dne, dn);
    n_cmp++; if (dn !== 1'b1) begin n_bad++; $display("FAIL nop_done: got %b want 1", dn); end
    read_reg(4'd3, v);
    n_cmp++; if (v !== 16'hFFFE) begin n_bad++; $display("FAIL nop_r3: got %h want fffe", v); end
    n_cmp++; if ({flag_gt_out, flag_eq_out, flag_lt_out} !== 3'b100) begin n_bad++; $display("FAIL nop_flags: got %b want 100", {flag_gt_out, flag_eq_out, flag_lt_out}); end
    do_alu(3'b000, 4'd0, 4'd1, 4'd2, 16'h0055, 1'b0, 1'b1, 1'b0,
           1'b0, 4'd0, 16'd0, d1, d0, sel, rdy, dne, dn);
    n_cmp++; if (dn !== 1'b1) begin n_bad++; $display("FAIL r0_done: got %b want 1", dn); end
    read_reg(4'd0, v);
    n_cmp++; if (v !== 16'd0) begin n_bad++; $display("FAIL r0_zero: got %h want 0000", v); end
    n_cmp++; if ({flag_gt_out, flag_eq_out, flag_lt_out} !== 3'b010) begin n_bad++; $display("FAIL r0_flags: got %b want 010", {flag_gt_out, flag_eq_out, flag_lt_out}); end
  endtask

  task automatic test_isqrt();
    logic [W-1:0] v;
    isqrt_ready_in = 1'b0;
    instr_valid_in = 1'b1;
    instr_op_in    = 3'b010;
    instr_rd_in    = 4'd6;
    instr_rsa_in   = 4'd1;
    instr_rsb_in   = 4'd0;
    tick();
    instr_valid_in = 1'b0;
    isqrt_done_in  = 1'b1;
    isqrt_res_in   = 16'h0BAD;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({isqrt_valid_out, isqrt_x_out} !== {1'b1, 16'd5}) begin n_bad++; $display("FAIL isq_hold[%0d]: got %b/%h want 1/0005", i, isqrt_valid_out, isqrt_x_out); end
      tick();
      isqrt_done_in = 1'b0;
    end
    isqrt_ready_in = 1'b1;
    tick();
    isqrt_ready_in = 1'b0;
    n_cmp++; if ({isqrt_valid_out, busy_out, done_out} !== 3'b010) begin n_bad++; $display("FAIL isq_wait_state: got %b want 010", {isqrt_valid_out, busy_out, done_out}); end
    tick();
    n_cmp++; if (done_out !== 1'b0) begin n_bad++; $display("FAIL isq_wait_nodone: got %b want 0", done_out); end
    isqrt_done_in = 1'b1;
    isqrt_res_in  = 16'h1234;
    tick();
    isqrt_done_in = 1'b0;
    isqrt_res_in  = 16'h0BAD;
    n_cmp++; if (done_out !== 1'b1) begin n_bad++; $display("FAIL isq_done: got %b want 1", done_out); end
    tick();
    read_reg(4'd6, v);
    n_cmp++; if (v !== 16'h1234) begin n_bad++; $display("FAIL isq_r6: got %h want 1234", v); end
    n_cmp++; if ({flag_gt_out, flag_eq_out, flag_lt_out} !== 3'b010) begin n_bad++; $display("FAIL isq_flags: got %b want 010", {flag_gt_out, flag_eq_out, flag_lt_out}); end
    n_cmp++; if (err_out !== 1'b0) begin n_bad++; $display("FAIL isq_err: got %b want 0", err_out); end
  endtask

  task automatic test_reset_mid_isqrt();
    logic [W-1:0] v;
    isqrt_ready_in = 1'b1;
    instr_valid_in = 1'b1;
    instr_op_in    = 3'b010;
    instr_rd_in    = 4'd6;
    instr_rsa_in   = 4'd1;
    tick();
    instr_valid_in = 1'b0;
    tick();
    isqrt_ready_in = 1'b0;
    #2;
    rst_n_in = 1'b0;
    #1;
    n_cmp++; if ({busy_out, instr_ready_out, done_out, isqrt_valid_out} !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_ctl: got %b want 0000", {busy_out, instr_ready_out, done_out, isqrt_valid_out}); end
    read_reg(4'd6, v);
    n_cmp++; if (v !== 16'd0) begin n_bad++; $display("FAIL rst_mid_r6: got %h want 0000", v); end
    isqrt_done_in = 1'b1;
    isqrt_res_in  = 16'h4321;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    isqrt_done_in = 1'b0;
    tick();
    n_cmp++; if ({instr_ready_out, busy_out, done_out} !== 3'b100) begin n_bad++; $display("FAIL rst_mid_idle: got %b want 100", {instr_ready_out, busy_out, done_out}); end
    tick();
    read_reg(4'd6, v);
    n_cmp++; if (v !== 16'd0) begin n_bad++; $display("FAIL rst_mid_r6_after: got %h want 0000", v); end
  endtask

`ifdef ALU_ISSUER_TIMEOUT_EN
  task automatic test_timeout();
    logic [W-1:0] v;
    logic         seen;
    seen = 1'b0;
    host_write(4'd1, 16'd5);
    isqrt_ready_in = 1'b0;
    instr_valid_in = 1'b1;
    instr_op_in    = 3'b010;
    instr_rd_in    = 4'd6;
    instr_rsa_in   = 4'd1;
    tick();
    instr_valid_in = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done_out) seen = 1'b1;
      else tick();
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL to_done: got %b want 1", seen); end
    tick();
    read_reg(4'd6, v);
    n_cmp++; if (v !== 16'h7FFF) begin n_bad++; $display("FAIL to_r6: got %h want 7fff", v); end
    n_cmp++; if (err_out !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", err_out); end
  endtask
`endif

  initial begin
    rst_n_in       = 1'b0;
    instr_valid_in = 1'b0;
    instr_op_in    = '0;
    instr_rd_in    = '0;
    instr_rsa_in   = '0;
    instr_rsb_in   = '0;
    wr_en_in       = 1'b0;
    wr_addr_in     = '0;
    wr_data_in     = '0;
    rd_addr_in     = '0;
    isqrt_ready_in = 1'b0;
    isqrt_done_in  = 1'b0;
    isqrt_res_in   = 16'h0BAD;
    alu_junk();
    test_reset();
    test_readback();
    test_sub();
    test_wb_conflict();
    test_nop_r0();
    test_isqrt();
    test_reset_mid_isqrt();
`ifdef ALU_ISSUER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
